// File: rtl/sa18_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the SA_18 tile sequencer.
package sa18_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_PRIME,
    S_READ,
    S_DONE
  } state_e;

  // Cycles for the last fed beat to ripple through the skewed grid.
  function automatic int drain_cycles(input int row_num, input int column_num,
                                      input int pe_latency);
    return row_num + column_num - 2 + pe_latency;
  endfunction

  function automatic int row_width(input int row_num);
    return (row_num > 1) ? $clog2(row_num) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sa18_cycle_counter.sv
// Loadable down-counter with a zero flag; shared by the FEED and DRAIN phases.
module sa18_cycle_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sa18_tile_ctrl.sv
// Tile sequencer: clear, feed k_len beats, drain the skew, then hand out one row per handshake.
module sa18_tile_ctrl
  import sa18_ctrl_pkg::*;
#(
  parameter int ROW_NUM    = 32,
  parameter int COLUMN_NUM = 32,
  parameter int PE_LATENCY = 1,
  parameter int K_WIDTH    = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [K_WIDTH-1:0]               k_len,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             feed_valid,
  output logic                             sa_reset,
  output logic                             sa_en,
  output logic                             sa_channel_out_reset,
  output logic                             sa_channel_out_en,
  output logic                             out_valid,
  output logic [row_width(ROW_NUM)-1:0]    out_row
);

  localparam int DRAIN_CYCLES = drain_cycles(ROW_NUM, COLUMN_NUM, PE_LATENCY);
  localparam int ROW_W        = row_width(ROW_NUM);
  localparam int CNT_W        = max_int(K_WIDTH, $clog2(DRAIN_CYCLES));

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROW_NUM - 1);

  state_e             state_q, state_d;
  logic [K_WIDTH-1:0] k_q;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]   cnt_load_value;

  sa18_cycle_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      if (state_q == S_IDLE && start) k_q <= k_len;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d              = state_q;
    row_d                = row_q;
    cnt_load             = 1'b0;
    cnt_dec              = 1'b0;
    cnt_load_value       = DRAIN_LOAD;
    done                 = 1'b0;
    feed_valid           = 1'b0;
    sa_reset             = 1'b0;
    sa_en                = 1'b0;
    sa_channel_out_reset = 1'b0;
    sa_channel_out_en    = 1'b0;
    out_valid            = 1'b0;

    unique case (state_q)
      S_IDLE: if (start) state_d = S_CLEAR;

      S_CLEAR: begin
        sa_reset             = 1'b1;
        sa_channel_out_reset = 1'b1;
        cnt_load             = 1'b1;
        if (k_q != '0) begin
          cnt_load_value = CNT_W'(k_q) - CNT_W'(1);
          state_d        = S_FEED;
        end else begin
          state_d = S_DRAIN;
        end
      end

      S_FEED: begin
        sa_en      = 1'b1;
        feed_valid = 1'b1;
        if (cnt_zero) begin
          cnt_load = 1'b1;
          state_d  = S_DRAIN;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      S_DRAIN: begin
        sa_en = 1'b1;
        if (cnt_zero) state_d = S_PRIME;
        else          cnt_dec = 1'b1;
      end

      // Moves the array row counter off its all-ones sentinel onto row 0.
      S_PRIME: begin
        sa_channel_out_en = 1'b1;
        row_d             = '0;
        state_d           = S_READ;
      end

      S_READ: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = S_DONE;
          end else begin
            sa_channel_out_en = 1'b1;
            row_d             = row_q + ROW_W'(1);
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        row_d   = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign out_row = row_q;

endmodule

// File: tb/tb_sa18_tile_ctrl.sv
// Directed bench for sa18_tile_ctrl: a 3x3 instance for cycle-exact checks and a 32x32 long-k run.
module tb_sa18_tile_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, out_ready, start_b;
  logic [15:0] k_len, k_len_b;

  logic       busy, done, feed_valid, sa_reset, sa_en, sa_cor, sa_coe, out_valid;
  logic [1:0] out_row;

  logic       busy_b, done_b, feed_b, sa_reset_b, sa_en_b, sa_cor_b, sa_coe_b, out_valid_b;
  logic [4:0] out_row_b;

  always #5 clk = ~clk;

  sa18_tile_ctrl #(.ROW_NUM(3), .COLUMN_NUM(3), .PE_LATENCY(1), .K_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .out_ready(out_ready),
    .busy(busy), .done(done), .feed_valid(feed_valid), .sa_reset(sa_reset),
    .sa_en(sa_en), .sa_channel_out_reset(sa_cor), .sa_channel_out_en(sa_coe),
    .out_valid(out_valid), .out_row(out_row)
  );

  sa18_tile_ctrl dut_big (
    .clk(clk), .reset(reset), .start(start_b), .k_len(k_len_b), .out_ready(out_ready),
    .busy(busy_b), .done(done_b), .feed_valid(feed_b), .sa_reset(sa_reset_b),
    .sa_en(sa_en_b), .sa_channel_out_reset(sa_cor_b), .sa_channel_out_en(sa_coe_b),
    .out_valid(out_valid_b), .out_row(out_row_b)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle trace of the 3x3 instance, bit c = value during cycle c.
  logic [63:0] m_rst, m_feed, m_en, m_cor, m_coe, m_valid, m_done, m_busy;
  logic [1:0]  rows [64];

  task automatic run_tile(input logic [15:0] k, input int n, input logic [63:0] start_at,
                          input logic [63:0] ready_low, input logic [63:0] reset_at);
    m_rst = '0; m_feed = '0; m_en = '0; m_cor = '0;
    m_coe = '0; m_valid = '0; m_done = '0; m_busy = '0;
    for (int c = 0; c < n; c++) begin
      start     = start_at[c];
      out_ready = !ready_low[c];
      reset     = reset_at[c];
      k_len     = k;
      @(negedge clk);
      m_rst[c]   = sa_reset;
      m_feed[c]  = feed_valid;
      m_en[c]    = sa_en;
      m_cor[c]   = sa_cor;
      m_coe[c]   = sa_coe;
      m_valid[c] = out_valid;
      m_done[c]  = done;
      m_busy[c]  = busy;
      rows[c]    = out_row;
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    reset     = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int feed_cnt, en_cnt, done_cyc;

    reset = 1'b1; start = 1'b0; out_ready = 1'b1; k_len = '0;
    start_b = 1'b0; k_len_b = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_idle_small",
          {56'd0, busy, done, feed_valid, sa_reset, sa_en, sa_cor, sa_coe, out_valid}, 64'd0);
    check("reset_idle_big",
          {51'd0, busy_b, done_b, feed_b, sa_reset_b, sa_en_b, sa_cor_b, sa_coe_b, out_valid_b,
           out_row_b}, 64'd0);
    @(posedge clk);
    #1;

    // k_len=4, continuous out_ready
    run_tile(16'd4, 20, 64'h1, 64'h0, 64'h0);
    check("t1_sa_reset",  m_rst,   64'h2);
    check("t1_ch_reset",  m_cor,   64'h2);
    check("t1_feed",      m_feed,  64'h3C);
    check("t1_en",        m_en,    64'h7FC);
    check("t1_ch_en",     m_coe,   64'h3800);
    check("t1_out_valid", m_valid, 64'h7000);
    check("t1_done",      m_done,  64'h8000);
    check("t1_busy",      m_busy,  64'hFFFE);
    check("t1_rows",      {58'd0, rows[12], rows[13], rows[14]}, 64'b00_01_10);

    // out_ready low in cycles 12-13
    run_tile(16'd4, 24, 64'h1, 64'h3000, 64'h0);
    check("t2_ch_en",     m_coe,   64'hC800);
    check("t2_out_valid", m_valid, 64'h1F000);
    check("t2_done",      m_done,  64'h20000);
    check("t2_busy",      m_busy,  64'h3FFFE);
    check("t2_rows",      {56'd0, rows[12], rows[13], rows[15], rows[16]}, 64'b00_00_01_10);

    // k_len=0 skips FEED
    run_tile(16'd0, 16, 64'h1, 64'h0, 64'h0);
    check("t3_feed", m_feed, 64'h0);
    check("t3_en",   m_en,   64'h7C);
    check("t3_ch_en", m_coe, 64'h380);
    check("t3_done", m_done, 64'h800);
    check("t3_busy", m_busy, 64'hFFE);

    // extra starts at cycles 3 and 8 are ignored
    run_tile(16'd4, 26, 64'h109, 64'h0, 64'h0);
    check("t4_done", m_done, 64'h8000);
    check("t4_busy", m_busy, 64'hFFFE);
    check("t4_sa_reset", m_rst, 64'h2);

    // reset mid-READ at cycle 13, restart at cycle 15
    run_tile(16'd4, 40, 64'h8001, 64'h0, 64'h2000);
    check("t5_pre_reset_row", {61'd0, m_valid[13], rows[13]}, 64'b101);
    check("t5_after_reset",
          {54'd0, m_busy[14], m_done[14], m_feed[14], m_rst[14], m_en[14], m_cor[14],
           m_coe[14], m_valid[14], rows[14]}, 64'd0);
    check("t5_sa_reset", m_rst,  64'h10002);
    check("t5_done",     m_done, 64'h4000_0000);
    check("t5_busy",     m_busy, 64'h7FFF_3FFE);

    // 32x32, k_len=65535
    start_b = 1'b1; k_len_b = 16'hFFFF; out_ready = 1'b1;
    feed_cnt = 0; en_cnt = 0; done_cyc = -1;
    for (int c = 0; c < 70000; c++) begin
      @(negedge clk);
      if (feed_b)  feed_cnt++;
      if (sa_en_b) en_cnt++;
      if (done_b) begin
        done_cyc = c;
        break;
      end
      @(posedge clk);
      #1;
      start_b = 1'b0;
    end
    start_b = 1'b0;
    check("big_feed_count", 64'(feed_cnt), 64'd65535);
    check("big_en_count",   64'(en_cnt),   64'd65598);
    check("big_done_cycle", 64'(done_cyc), 64'd65633);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
